// File: rtl/ex_mem_if.sv
// ex_mem_if: ALU-side bundle, data-memory handshake and writeback/redirect outputs of the EX/MEM stage.
interface ex_mem_if #(
    parameter int ADDR_W = 16,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_opcode;
    logic [31:0]       in_rd;
    logic [31:0]       in_rd_mem;
    logic [31:0]       in_branch;
    logic [31:0]       in_alu_result;
    logic [31:0]       in_mem_result;
    logic [31:0]       in_mem_addr;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_addr;
    logic [31:0]       wb_data;
    logic              br_taken;
    logic [31:0]       br_target;
    logic              mem_err;
    modport master (
        output in_valid, in_opcode, in_rd, in_rd_mem, in_branch, in_alu_result, in_mem_result, in_mem_addr,
        output mem_ack, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_addr, wb_data, br_taken, br_target, mem_err
    );
    modport slave (
        input  in_valid, in_opcode, in_rd, in_rd_mem, in_branch, in_alu_result, in_mem_result, in_mem_addr,
        input  mem_ack, mem_rdata,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_addr, wb_data, br_taken, br_target, mem_err
    );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: dispatches ALU bundles to writeback, branch redirect or a watchdog-guarded data-memory access.
module ex_mem_stage #(
    parameter int ADDR_W      = 16,
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input logic    clk,
    input logic    rst,
    ex_mem_if.slave bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    typedef enum logic {IDLE, MEM} state_t;
    state_t            state, nxt;
    logic [CW-1:0]     cnt;
    logic [REG_AW-1:0] dst;
    logic              acc, is_wb, is_cp, is_gp, is_br, timeout, load_done;
    always_comb begin
        acc       = bus.in_valid && state == IDLE;
        is_wb     = bus.in_opcode inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd9, 5'd12};
        is_cp     = bus.in_opcode == 5'd6;
        is_gp     = bus.in_opcode == 5'd10;
        is_br     = bus.in_opcode == 5'd7 || (bus.in_opcode == 5'd8 && bus.in_branch != 32'd0);
        // ack on the limit edge wins over the watchdog
        timeout   = state == MEM && !bus.mem_ack && cnt == CW'(MEM_TIMEOUT - 1);
        load_done = state == MEM && bus.mem_ack && !bus.mem_we;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= (state == MEM && !bus.mem_ack && !timeout) ? cnt + 1'b1 : '0;
        end
    end
    always_comb begin
        nxt = state;
        if (state == IDLE)
            nxt = (acc && (is_cp || is_gp)) ? MEM : IDLE;
        else
            nxt = (bus.mem_ack || timeout) ? IDLE : MEM;
    end
    always_comb begin
        bus.in_ready = state == IDLE;
        bus.mem_req  = state == MEM;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            dst           <= '0;
            bus.wb_valid  <= 1'b0;
            bus.wb_addr   <= '0;
            bus.wb_data   <= '0;
            bus.br_taken  <= 1'b0;
            bus.br_target <= '0;
            bus.mem_err   <= 1'b0;
        end else begin
            bus.wb_valid <= (acc && is_wb) || load_done;
            bus.br_taken <= acc && is_br;
            bus.mem_err  <= bus.mem_err || timeout;
            if (load_done) begin
                bus.wb_addr <= dst;
                bus.wb_data <= bus.mem_rdata;
            end else if (acc && is_wb) begin
                bus.wb_addr <= bus.in_rd[REG_AW-1:0];
                bus.wb_data <= bus.in_alu_result;
            end
            if (acc && is_br) bus.br_target <= bus.in_branch;
            if (acc && (is_cp || is_gp)) begin
                bus.mem_we    <= is_cp;
                bus.mem_addr  <= is_cp ? bus.in_rd_mem[ADDR_W-1:0] : bus.in_mem_addr[ADDR_W-1:0];
                bus.mem_wdata <= is_cp ? bus.in_mem_result : 32'd0;
                dst           <= bus.in_rd_mem[REG_AW-1:0];
            end
        end
    end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Stage directly downstream of the ALU.
- Captures one ALU result bundle per handshake and dispatches it by opcode class: register writeback, data-memory store (CP), data-memory load (GP), or branch redirect (B/BEG).
- Runs multi-cycle data-memory accesses through a req/ack handshake with a timeout watchdog.
- Holds off the ALU via in_ready while an access is outstanding.

Parameters:
- ADDR_W, 16, data-memory address width; the low ADDR_W bits of the 32-bit address are used.
- REG_AW, 5, register-file index width; the low REG_AW bits of the destination are used.
- MEM_TIMEOUT, 255, maximum cycles mem_req may wait for mem_ack before abort.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU bundle valid.
- in_ready  out  1  stage can accept a bundle this cycle.
- in_opcode  in  5  ALU OpCode output.
- in_rd  in  32  ALU RdOut, register destination.
- in_rd_mem  in  32  ALU RdMem: store address (CP), load destination register (GP).
- in_branch  in  32  ALU branchResult, branch target; 0 means not taken for BEG.
- in_alu_result  in  32  ALU AluResult.
- in_mem_result  in  32  ALU MemResult, store data.
- in_mem_addr  in  32  ALU MemOut, load address (GP).
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = store, 0 = load.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  store data.
- mem_ack  in  1  memory completion, single-cycle pulse.
- mem_rdata  in  32  load data, valid when mem_ack = 1.
- wb_valid  out  1  one-cycle register write pulse.
- wb_addr  out  REG_AW  destination register.
- wb_data  out  32  write data.
- br_taken  out  1  one-cycle redirect pulse.
- br_target  out  32  redirect PC.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset: every output is 0 except in_ready, which is 1. State = IDLE, timeout counter = 0, mem_err = 0. Reset mid-access drops mem_req at that edge and discards the pending bundle. A late mem_ack after reset is ignored.
- States:
  - IDLE: accepting.
  - MEM: access outstanding.
- in_ready = (state == IDLE). A bundle is accepted on in_valid & in_ready.
- Opcode classes, decided on accept:
  - 1, 2, 3, 4, 5, 9, 12: writeback. Next cycle wb_valid=1, wb_addr=in_rd[REG_AW-1:0], wb_data=in_alu_result. State stays IDLE. Latency 1, throughput 1/cycle.
  - 6 (CP): store. Next cycle enter MEM with mem_req=1, mem_we=1, mem_addr=in_rd_mem[ADDR_W-1:0], mem_wdata=in_mem_result.
  - 10 (GP): load. Next cycle enter MEM with mem_req=1, mem_we=0, mem_addr=in_mem_addr[ADDR_W-1:0]. The destination in_rd_mem[REG_AW-1:0] is latched.
  - 7 (B): next cycle br_taken=1, br_target=in_branch.
  - 8 (BEG): next cycle br_taken=1, br_target=in_branch only if in_branch != 0; otherwise no output.
  - 0 and every other code: no outputs, no state change.
- MEM rules:
  - mem_req, mem_we, mem_addr and mem_wdata hold stable until the mem_ack edge.
  - On the ack edge: mem_req drops and state returns to IDLE.
  - Load: the cycle after the ack edge, wb_valid=1, wb_data=mem_rdata captured at ack, wb_addr=latched destination.
  - in_ready is 0 during every MEM cycle, including the ack cycle. The next bundle is accepted no earlier than the cycle after ack.
- Timeout:
  - The counter increments each MEM cycle without ack.
  - When it reaches MEM_TIMEOUT with no ack: mem_req drops, state returns to IDLE, mem_err is set, and no writeback occurs.
  - mem_err stays set until rst.
  - An ack on the same edge the limit is reached counts as success.
- mem_ack while in IDLE is ignored.
- wb_valid and br_taken are never asserted together; each pulse lasts exactly one cycle.
- Address truncation is silent; upper bits are ignored.

Test Plan:
- Reset, then in_opcode=5, in_rd=3, in_alu_result=0x12, valid one cycle -> next cycle wb_valid=1, wb_addr=3, wb_data=0x12. Following cycle wb_valid=0.
- Back-to-back opcode 2 then 4 on consecutive cycles -> two consecutive wb pulses with matching data. in_ready stays 1 throughout.
- CP, in_rd_mem=0x0040, in_mem_result=0xABCD, ack after 3 cycles -> mem_req=1 and mem_we=1 for exactly 3 cycles with stable addr/data. in_ready=0 in those cycles. No wb pulse.
- GP, in_mem_addr=0x10, in_rd_mem=7, ack with rdata=0x55 after 2 cycles -> the cycle after ack, wb_valid=1, wb_addr=7, wb_data=0x55.
- BEG with in_branch=0 -> no br_taken. BEG with in_branch=0x20 -> br_taken=1, br_target=0x20. B with 0x8 -> br_taken=1, br_target=0x8.
- MEM_TIMEOUT=4, GP with no ack -> mem_req drops after 4 cycles, mem_err=1, no wb. Then rst -> mem_err=0. Also: rst asserted mid-MEM -> mem_req=0 on that edge, and a later ack produces no wb.
